// File: rtl/sub_pipe_64bit_if.sv
// Operand/result bundle for the pipelined 64-bit subtractor.
// The master drives operands and the slave (the subtractor) returns results.
interface sub_pipe_64bit_if #(
    parameter int WIDTH = 64
);
    logic             i_en;
    logic [WIDTH-1:0] mina;
    logic [WIDTH-1:0] subb;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             o_en;

    modport master (
        output i_en, mina, subb,
        input  diff, borrow, ovf, o_en
    );

    modport slave (
        input  i_en, mina, subb,
        output diff, borrow, ovf, o_en
    );
endinterface

// File: rtl/sub_pipe_64bit.sv
// Pipelined 64-bit subtractor: one 16-bit segment per stage, borrow rippling
// one stage per clock, results registered four clocks after capture.
module sub_pipe_64bit #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    sub_pipe_64bit_if.slave bus
);
    localparam int NSTG = WIDTH / SEG;

    // Per stage: partial difference, delayed operands, segment borrow, valid.
    logic [WIDTH-1:0] r_res [NSTG];
    logic [WIDTH-1:0] r_opa [NSTG];
    logic [WIDTH-1:0] r_opb [NSTG];
    logic [NSTG-1:0]  r_brw;
    logic [NSTG-1:0]  r_vld;
    logic [SEG:0]     w_seg [NSTG];

    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_o_en;
    logic             w_ovf;

    // Bit SEG of the zero-extended difference is set exactly when a < b + bin.
    assign w_seg[0] = {1'b0, bus.mina[SEG-1:0]} - {1'b0, bus.subb[SEG-1:0]};

    generate
        for (genvar gi = 1; gi < NSTG; gi++) begin : g_seg
            assign w_seg[gi] = {1'b0, r_opa[gi-1][gi*SEG +: SEG]}
                             - {1'b0, r_opb[gi-1][gi*SEG +: SEG]}
                             - {{SEG{1'b0}}, r_brw[gi-1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                r_res[k] <= '0;
                r_opa[k] <= '0;
                r_opb[k] <= '0;
            end
            r_brw <= '0;
            r_vld <= '0;
        end else begin
            r_vld[0] <= bus.i_en;
            r_res[0] <= {{(WIDTH-SEG){1'b0}}, w_seg[0][SEG-1:0]};
            r_brw[0] <= w_seg[0][SEG];
            r_opa[0] <= bus.mina;
            r_opb[0] <= bus.subb;
            for (int k = 1; k < NSTG; k++) begin
                r_vld[k]                 <= r_vld[k-1];
                r_res[k]                 <= r_res[k-1];
                r_res[k][k*SEG +: SEG]   <= w_seg[k][SEG-1:0];
                r_brw[k]                 <= w_seg[k][SEG];
                r_opa[k]                 <= r_opa[k-1];
                r_opb[k]                 <= r_opb[k-1];
            end
        end
    end

    assign w_ovf = (r_opa[NSTG-1][WIDTH-1] != r_opb[NSTG-1][WIDTH-1])
                && (r_res[NSTG-1][WIDTH-1] != r_opa[NSTG-1][WIDTH-1]);

    // Results hold between valid operations so diff keeps the last answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_o_en   <= 1'b0;
        end else begin
            r_o_en <= r_vld[NSTG-1];
            if (r_vld[NSTG-1]) begin
                r_diff   <= r_res[NSTG-1];
                r_borrow <= r_brw[NSTG-1];
                r_ovf    <= w_ovf;
            end
        end
    end

    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
    assign bus.ovf    = r_ovf;
    assign bus.o_en   = r_o_en;
endmodule

// File: tb/tb_sub_pipe_64bit.sv
// Randomized bench for sub_pipe_64bit with a 4-cycle-delayed scoreboard.
module tb_sub_pipe_64bit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sub_pipe_64bit_if #(.WIDTH(64)) bus ();

    sub_pipe_64bit #(.WIDTH(64), .SEG(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [63:0] d;
        logic        b;
        logic        o;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    string       phase = "init";
    logic [63:0] last_d = '0;
    logic        last_b = 1'b0;
    logic        last_o = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s/%s: got %h want %h (cycle %0d)", phase, tag, obs, exp_v, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic plus a 65-bit signed difference.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int due);
        exp_t               e;
        logic signed [64:0] s;
        s     = $signed({a[63], a}) - $signed({b[63], b});
        e.due = due;
        e.d   = a - b;
        e.b   = (a < b);
        e.o   = (s[64] != s[63]);
        return e;
    endfunction

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 9))
            0:       v = 64'h0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    task automatic check_outputs();
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("o_en",   64'(bus.o_en),   64'd1);
            chk("diff",   bus.diff,        e.d);
            chk("borrow", 64'(bus.borrow), 64'(e.b));
            chk("ovf",    64'(bus.ovf),    64'(e.o));
            $display("cycle %0d %s: diff=%h borrow=%0b ovf=%0b", cyc, phase, bus.diff, bus.borrow, bus.ovf);
            last_d = e.d;
            last_b = e.b;
            last_o = e.o;
        end else begin
            chk("o_en_idle",   64'(bus.o_en),   64'd0);
            chk("diff_hold",   bus.diff,        last_d);
            chk("borrow_hold", 64'(bus.borrow), 64'(last_b));
            chk("ovf_hold",    64'(bus.ovf),    64'(last_o));
        end
    endtask

    task automatic step(input logic en, input logic [63:0] a, input logic [63:0] b);
        bus.i_en = en;
        bus.mina = a;
        bus.subb = b;
        @(posedge clk);
        cyc++;
        if (en) sb_q.push_back(model(a, b, cyc + 4));
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, pick_operand(), pick_operand());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_diff"},   bus.diff,        64'd0);
        chk({tag, "_borrow"}, 64'(bus.borrow), 64'd0);
        chk({tag, "_ovf"},    64'(bus.ovf),    64'd0);
        chk({tag, "_o_en"},   64'(bus.o_en),   64'd0);
    endtask

    // Called away from a clock edge; holds reset for n rising edges.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sb_q.delete();
        last_d = '0;
        last_b = 1'b0;
        last_o = 1'b0;
        #1;
        check_zero("rst_now");
        for (int i = 0; i < n; i++) begin
            bus.i_en = 1'b1;
            bus.mina = {$urandom(), $urandom()};
            bus.subb = {$urandom(), $urandom()};
            @(posedge clk);
            cyc++;
            #1;
            check_zero("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.i_en = 1'b0;
        bus.mina = '0;
        bus.subb = '0;
        #2;

        phase = "reset";
        do_reset(5);
        idle(10);

        phase = "basic";
        step(1'b1, 64'd5, 64'd3);
        idle(6);

        phase = "ripple";
        step(1'b1, 64'd0, 64'd1);
        step(1'b1, 64'h0001_0000_0000_0000, 64'd1);
        idle(5);

        phase = "ovf";
        step(1'b1, 64'h8000_0000_0000_0000, 64'd1);
        step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(5);

        phase = "stream";
        step(1'b1, 64'd10, 64'd1);
        step(1'b1, 64'd20, 64'd2);
        step(1'b1, 64'd30, 64'd3);
        step(1'b1, 64'd0,  64'd5);
        step(1'b0, 64'd0,  64'd0);
        step(1'b1, 64'd7,  64'd7);
        idle(6);

        phase = "midrst";
        step(1'b1, 64'd11, 64'd1);
        step(1'b1, 64'd12, 64'd2);
        step(1'b1, 64'd13, 64'd3);
        step(1'b0, 64'd0,  64'd0);
        do_reset(1);
        step(1'b1, 64'd100, 64'd1);
        idle(6);

        phase = "random";
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 3) != 0, pick_operand(), pick_operand());
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
